// File: rtl/poly_arith.sv
// poly_arith: APB peripheral applying add / sub / Montgomery multiply mod Q
// lane-parallel over two interleaved coefficient banks, writing results back into bank A.
module poly_arith #(
   parameter int unsigned N     = 256,
   parameter int unsigned LANES = 4,
   parameter int unsigned Q     = 8380417,
   parameter int unsigned CW    = 23,
   parameter logic [31:0] QINV  = 32'd4236238847
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic [15:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic        poly_arith_irq
);
   localparam int unsigned ROWS  = N / LANES;
   localparam int unsigned LOGN  = $clog2(N);
   localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [16:0] A_END = 17'(4 * N);
   localparam logic [16:0] B_END = 17'(8 * N);
   localparam logic [CW:0] QX    = (CW + 1)'(Q);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;

   logic xfer, is_a, is_b, is_bank, is_ctrl, busy;
   logic ctrl_wr, start_req, start_ok, start_err, bank_rd_ok, a_wr, b_wr;
   logic [LOGN-1:0] idx;
   logic [LW-1:0] lane;
   logic [RW-1:0] row;
   logic rd_pend, done, err, ie, wb, wb_done;
   logic [1:0] op;
   logic [RW-1:0] rd_row, r1, r2, r3, wb_row;
   logic v1, v2, v3;
   logic [CW-1:0] lane_rd_a [LANES];
   logic [CW-1:0] lane_rd_b [LANES];
   logic [31:0] status;
   logic pwdata_unused;

   assign xfer    = psel & penable;
   assign is_a    = (paddr[1:0] == 2'b00) && ({1'b0, paddr} < A_END);
   assign is_b    = (paddr[1:0] == 2'b00) && ({1'b0, paddr} >= A_END) && ({1'b0, paddr} < B_END);
   assign is_bank = is_a | is_b;
   assign is_ctrl = (paddr == 16'hFFFC);
   assign idx     = paddr[LOGN+1:2];
   assign lane    = LW'(idx % LANES);
   assign row     = RW'(idx / LANES);
   assign busy    = (state != IDLE);

   assign ctrl_wr    = xfer & pwrite & is_ctrl;
   assign start_req  = ctrl_wr & pwdata[4];
   assign start_ok   = start_req & ~busy & (pwdata[1:0] != 2'd3);
   assign start_err  = start_req & (busy | (pwdata[1:0] == 2'd3));
   assign bank_rd_ok = xfer & ~pwrite & is_bank & ~busy;
   assign a_wr       = xfer & pwrite & is_a & ~busy;
   assign b_wr       = xfer & pwrite & is_b & ~busy;
   assign pwdata_unused = ^pwdata[31:CW];

   // Only an idle bank read takes a wait state; everything else, errors included, completes at once.
   assign pready  = xfer & (~bank_rd_ok | rd_pend);
   assign pslverr = pready & (~is_bank & ~is_ctrl | (is_bank & busy) | start_err);
   assign status  = {23'd0, ie, 5'd0, err, done, busy};
   assign poly_arith_irq = done & ie;

   always_comb begin
      prdata = '0;
      if (pready & ~pwrite) begin
         if (is_ctrl)
            prdata = status;
         else if (bank_rd_ok)
            prdata = {{(32 - CW){1'b0}}, is_a ? lane_rd_a[lane] : lane_rd_b[lane]};
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start_ok) state_nx = RUN;
         RUN:     if (rd_row == LAST_ROW) state_nx = DRAIN;
         DRAIN:   if (wb_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Write-back tap: add/sub retire one stage after the group read, mul three stages later.
   assign wb     = (op == 2'd2) ? v3 : v1;
   assign wb_row = (op == 2'd2) ? r3 : r1;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rd_pend <= 1'b0;
         rd_row  <= '0;
         op      <= 2'd0;
         {v1, v2, v3} <= 3'b000;
         r1      <= '0;
         r2      <= '0;
         r3      <= '0;
         wb_done <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         ie      <= 1'b0;
      end else begin
         rd_pend <= bank_rd_ok & ~rd_pend;
         v1      <= (state == RUN);
         r1      <= rd_row;
         v2      <= v1;
         r2      <= r1;
         v3      <= v2;
         r3      <= r2;
         wb_done <= wb & (wb_row == LAST_ROW);
         if (state == RUN)
            rd_row <= rd_row + 1'b1;
         if (ctrl_wr) begin
            ie <= pwdata[8];
            if (pwdata[5]) begin
               done <= 1'b0;
               err  <= 1'b0;
            end
         end
         if (start_ok) begin
            op     <= pwdata[1:0];
            rd_row <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
         end else if (start_req & ~busy) begin
            err <= 1'b1;
         end
         if ((state == DRAIN) && wb_done)
            done <= 1'b1;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam logic [LW-1:0] LID = LW'(l);
      logic [CW-1:0] bank_a [ROWS];
      logic [CW-1:0] bank_b [ROWS];
      logic [CW-1:0] s1_a, s1_b, rd_a_q, rd_b_q, res;
      logic [63:0] s2_t, s3_t;
      logic [31:0] s3_m, red, mont_unused;
      logic [CW:0] sum;

      // Montgomery reduction: the low word of t + m*Q is zero by construction of m.
      assign sum = {1'b0, s1_a} + {1'b0, s1_b};
      assign {red, mont_unused} = s3_t + ({32'd0, s3_m} * 64'(Q));

      always_comb begin
         res = '0;
         unique case (op)
            2'd1:    res = (s1_a >= s1_b) ? s1_a - s1_b : CW'({1'b0, s1_a} + QX - {1'b0, s1_b});
            2'd2:    res = (red >= Q) ? CW'(red - Q) : CW'(red);
            default: res = (sum >= QX) ? CW'(sum - QX) : CW'(sum);
         endcase
      end

      always_ff @(posedge pclk) begin
         s1_a   <= bank_a[rd_row];
         s1_b   <= bank_b[rd_row];
         s2_t   <= 64'(s1_a) * 64'(s1_b);
         s3_t   <= s2_t;
         s3_m   <= s2_t[31:0] * QINV;
         rd_a_q <= bank_a[row];
         rd_b_q <= bank_b[row];
         if (wb)
            bank_a[wb_row] <= res;
         if (a_wr && (lane == LID))
            bank_a[row] <= pwdata[CW-1:0];
         if (b_wr && (lane == LID))
            bank_b[row] <= pwdata[CW-1:0];
      end

      assign lane_rd_a[l] = rd_a_q;
      assign lane_rd_b[l] = rd_b_q;
   end
endmodule
